// File: rtl/lab8_pkg.sv
// Shared definitions for the push-button debouncer.
// State encodings and the default 5 ms qualification window at 100 MHz.
package lab8_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } db_state_e;

    localparam int unsigned DEBOUNCE_100MHZ_5MS = 500000;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into clk.
// Flops are chained back to back with no logic in between.
module sync_chain #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    // Synchroniser register bank, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchroniser plus a 4-state qualify FSM.
// A level change is accepted only after STABLE_CYCLES equal samples.
module button_debouncer
    import lab8_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_100MHZ_5MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic db_out,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic s;

    db_state_e state_q;
    db_state_e state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic db_q;
    logic db_d;

    sync_chain #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_in),
        .q    (s)
    );

    // Next-state, counter and output level; aborts give no partial credit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_HIGH;
                    db_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LOW;
                    db_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                db_d    = 1'b0;
            end
        endcase
    end

    // State, counter and debounced-level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign db_out = db_q;
    assign busy   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_debouncer;

    logic clk;
    logic rst_n;
    logic btn_in;
    logic db_out;
    logic busy;

    int checks;
    int errors;
    int z_cnt;
    int z_base;
    logic db_prev;

    logic [1:12] bz;
    logic [1:10] bp;

    button_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_in(btn_in),
        .db_out(db_out),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Rising-edge detector on db_out standing in for the downstream block.
    always @(negedge clk) begin
        if (rst_n && db_out && !db_prev) begin
            z_cnt <= z_cnt + 1;
        end
        db_prev <= db_out;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Hold btn_in at lvl; busy on edges 3..6, db_out flips after edge 7.
    task automatic qualify(input logic lvl, input string tag);
        btn_in = lvl;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            check($sformatf("%s_busy_e%0d", tag, e), busy,
                  (e >= 3 && e <= 6));
            check($sformatf("%s_db_e%0d", tag, e), db_out,
                  (e >= 7) ? lvl : ~lvl);
        end
    endtask

    // Bouncing press 1,0,1,1,0,1,1,1,1,1 then held high.
    task automatic bounce_press(input string tag);
        for (int e = 1; e <= 12; e++) begin
            btn_in = (e <= 10) ? bp[e] : 1'b1;
            @(negedge clk);
            check($sformatf("%s_busy_e%0d", tag, e), busy, bz[e]);
            check($sformatf("%s_db_e%0d", tag, e), db_out, (e >= 12));
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        z_cnt   = 0;
        z_base  = 0;
        db_prev = 1'b0;
        bz      = 12'b001011011110;
        bp      = 10'b1011011111;
        clk     = 1'b0;
        rst_n   = 1'b0;
        btn_in  = 1'b1;

        // 1. reset with button held, then release
        @(negedge clk);
        @(negedge clk);
        check("rst_db", db_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        qualify(1'b1, "rst_rel");

        // 2. clean release / press / release
        qualify(1'b0, "rel");
        qualify(1'b1, "press");
        qualify(1'b0, "rel2");

        // 3. bouncing press
        bounce_press("bounce");

        // 4. short glitch never reaches db_out
        qualify(1'b0, "rel3");
        for (int e = 1; e <= 10; e++) begin
            btn_in = (e <= 3);
            @(negedge clk);
            check($sformatf("glitch_busy_e%0d", e), busy,
                  (e >= 3 && e <= 5));
            check($sformatf("glitch_db_e%0d", e), db_out, 1'b0);
        end

        // 5. reset in WAIT_HIGH with cnt=2
        btn_in = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy_pre", busy, 1'b1);
        check("mid_db_pre", db_out, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_db_rst", db_out, 1'b0);
        check("mid_busy_rst", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_hold", busy, 1'b0);
        rst_n = 1'b1;
        qualify(1'b1, "post_rst");

        // 6. chain: one z pulse per accepted press
        @(negedge clk);
        #2 z_base = z_cnt;
        qualify(1'b0, "ch_rel0");
        bounce_press("ch_bounce");
        qualify(1'b0, "ch_rel1");
        qualify(1'b1, "ch_press");
        qualify(1'b0, "ch_rel2");
        @(negedge clk);
        #2;
        checks++;
        assert ((z_cnt - z_base) === 2) else begin
            errors++;
            $error("FAIL chain_z: got %0d expected 2", z_cnt - z_base);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
